timing_pulse_generator: RTL and testbench
=========================================

Name: timing_pulse_generator

Overview:
- Upstream neighbour of the service-gate stage.
- Produces the memory-cycle time pulses (T01_n..T12_n) and the per-time-pulse phase strobes (P01_n..P04_n, RT_n, CT_n, WT_n, TT_n) that the service gates AND with control pulses to form read, clear and write gates.
- Also implements monitor stop and single-MCT step, GOJAM restart, and an MCT counter for bench and monitor visibility.

Parameters:
- T_PER_MCT, 12, time pulses per memory cycle (T01..T12); fixed at 12 for this design.
- PH_PER_T, 4, SIM_CLK cycles (phases) per time pulse.
- MCT_W, 16, width of the MCT counter.

Ports:
- SIM_CLK  in  1  simulation clock; all state changes on rising edge.
- SIM_RST  in  1  reset, synchronous, active-high.
- p4VSW  in  1  supply rail; no logic function.
- GND  in  1  ground rail; no logic function.
- GOJAM  in  1  synchronous restart request, active-high.
- MSTP  in  1  monitor stop request, level, active-high.
- MSTRT  in  1  monitor start/step, level; rising edge is used.
- T_n  out  12  time pulses, one-hot active-low; bit k-1 is Tk_n.
- T10_n  out  1  copy of T_n[9].
- P01_n, P02_n, P03_n, P04_n  out  1 each  phase strobes, active-low.
- RT_n  out  1  read timing; equals P01_n.
- CT_n  out  1  clear timing; equals P02_n.
- WT_n  out  1  write timing; equals P03_n.
- TT_n  out  1  transfer timing; equals P04_n.
- STOPPED  out  1  high while halted.
- MCT_CNT  out  MCT_W  completed memory cycles, wraps modulo 2^MCT_W.

Behaviour:
- State registers:
  - tp: 0..11, the time pulse index.
  - ph: 0..PH_PER_T-1, the phase index.
  - run/stop FSM with states RUN, STOPPED.
  - mstrt_q: previous MSTRT level.
- All outputs are registered, so each output reflects the state of the current cycle.
- Reset:
  - tp=0, ph=0, FSM=RUN, MCT_CNT=0, mstrt_q=0.
  - The first cycle after reset drives T_n=12'hFFE (T01 low), P01_n=RT_n=0, and all other strobes 1.
- RUN:
  - ph increments each cycle.
  - At ph=PH_PER_T-1, ph wraps to 0 and tp increments.
  - When tp=11 and ph wraps, tp returns to 0 and MCT_CNT increments.
  - Exactly one T_n bit is low at all times in RUN.
  - Exactly one of P01..P04 is low while ph<4.
  - If PH_PER_T>4, phases 4 and above drive all P strobes high (idle phases).
- Stop:
  - MSTP is sampled only on the last cycle of T12 (tp=11, ph=PH_PER_T-1).
  - If MSTP=1 at that point, the next state is STOPPED: tp=0, ph=0, T_n all ones, all strobes high, STOPPED=1. MCT_CNT still increments for the completed cycle.
  - MSTP changing at any other time has no effect until the end of the current MCT.
- STOPPED:
  - Holds until a rising edge of MSTRT is detected (MSTRT=1, mstrt_q=0).
  - On the next cycle the FSM enters RUN at T01/P01 and runs exactly one full MCT.
  - At the end of that MCT MSTP is re-sampled: still high means STOPPED again; low means continuous RUN.
  - A level-high MSTRT without an edge does not step.
  - Clearing MSTP while STOPPED does not resume; an MSTRT edge is still required.
- GOJAM:
  - Highest priority below SIM_RST.
  - When GOJAM=1: next cycle tp=0, ph=0, FSM=RUN regardless of MSTP or current state. MCT_CNT is not incremented for the aborted cycle.
  - GOJAM held high keeps the block at T01/P01 with RT_n low every cycle.
- Priority: SIM_RST > GOJAM > end-of-MCT stop check > MSTRT step.
- SIM_RST asserted mid-MCT: the next cycle is the reset state. No partial strobes, no glitches between cycles.
- MSTRT edge detection updates mstrt_q every cycle, including in RUN. An edge arriving during RUN is discarded and not remembered.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then run 48 cycles with PH_PER_T=4 -> T_n walks 12'hFFE..12'h7FF, each value held 4 cycles. RT_n/CT_n/WT_n/TT_n are low in phases 0/1/2/3. T10_n is low at cycles 36..39. MCT_CNT=1 at cycle 48.
2. Assert MSTP at cycle 10 -> the MCT completes. At cycle 48: STOPPED=1, T_n=12'hFFF, all strobes high, MCT_CNT=1. The state holds for 100 cycles.
3. While stopped with MSTP=1, pulse MSTRT high for 5 cycles -> exactly 48 RUN cycles, then STOPPED=1 again and MCT_CNT=2. Holding MSTRT high longer gives no further steps.
4. Assert GOJAM at tp=6, ph=2 for 1 cycle -> the next cycle is T01/P01 (T_n=12'hFFE, RT_n=0) and MCT_CNT is unchanged. Assert GOJAM while STOPPED -> the block resumes RUN.
5. Assert SIM_RST at tp=9, ph=3 -> the next cycle is the reset state and MCT_CNT=0. Check with GOJAM and SIM_RST both high -> reset state.
6. Preload MCT_CNT near wrap by running 2^MCT_W-1 MCTs with MCT_W=4 -> the counter wraps 15 -> 0 with T/P sequencing unaffected. With PH_PER_T=6, phases 4-5 drive all strobes high.

Source files
------------

// File: rtl/timing_pulse_generator.sv
// Memory-cycle timing generator: walks T01..T12 with PH_PER_T phases each and
// drives active-low time pulses and phase strobes. Also handles monitor stop/step and GOJAM restart.
module timing_pulse_generator #(
  parameter int T_PER_MCT = 12,
  parameter int PH_PER_T  = 4,
  parameter int MCT_W     = 16
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 p4VSW,
  input  logic                 GND,
  input  logic                 GOJAM,
  input  logic                 MSTP,
  input  logic                 MSTRT,
  output logic [T_PER_MCT-1:0] T_n,
  output logic                 T10_n,
  output logic                 P01_n,
  output logic                 P02_n,
  output logic                 P03_n,
  output logic                 P04_n,
  output logic                 RT_n,
  output logic                 CT_n,
  output logic                 WT_n,
  output logic                 TT_n,
  output logic                 STOPPED,
  output logic [MCT_W-1:0]     MCT_CNT
);

  localparam int TP_W = 4;
  localparam int PH_W = (PH_PER_T > 1) ? $clog2(PH_PER_T) : 1;
  localparam logic [TP_W-1:0] TP_LAST = TP_W'(T_PER_MCT - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH_PER_T - 1);

  typedef enum logic {
    S_RUN     = 1'b0,
    S_STOPPED = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [TP_W-1:0]        tp_q, tp_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [MCT_W-1:0]       mct_q, mct_d;
  logic                   mstrt_q;
  logic [T_PER_MCT-1:0]   t_n_q, t_n_d;
  logic [3:0]             p_n_q, p_n_d;

  // Supply rails carry no logic; fold them into a deliberately unused net.
  logic unused_rails;
  assign unused_rails = &{1'b0, p4VSW, GND};

  always_comb begin : next_state
    state_d = state_q;
    tp_d    = tp_q;
    ph_d    = ph_q;
    mct_d   = mct_q;
    if (GOJAM) begin
      state_d = S_RUN;
      tp_d    = '0;
      ph_d    = '0;
    end else if (state_q == S_RUN) begin
      if (ph_q == PH_LAST) begin
        ph_d = '0;
        if (tp_q == TP_LAST) begin
          // End of T12: count the completed MCT and sample the stop request.
          tp_d  = '0;
          mct_d = mct_q + 1'b1;
          if (MSTP) state_d = S_STOPPED;
        end else begin
          tp_d = tp_q + 1'b1;
        end
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end else if (MSTRT && !mstrt_q) begin
      state_d = S_RUN;
      tp_d    = '0;
      ph_d    = '0;
    end
  end

  // Outputs are decoded from next state and registered, so they change only on clock edges.
  always_comb begin : output_decode
    t_n_d = '1;
    p_n_d = '1;
    if (state_d == S_RUN) begin
      for (int k = 0; k < T_PER_MCT; k++) begin
        if (tp_d == TP_W'(k)) t_n_d[k] = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        if (ph_d == PH_W'(k)) p_n_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q <= S_RUN;
      tp_q    <= '0;
      ph_q    <= '0;
      mct_q   <= '0;
      mstrt_q <= 1'b0;
      t_n_q   <= {{(T_PER_MCT-1){1'b1}}, 1'b0};
      p_n_q   <= 4'b1110;
    end else begin
      state_q <= state_d;
      tp_q    <= tp_d;
      ph_q    <= ph_d;
      mct_q   <= mct_d;
      mstrt_q <= MSTRT;
      t_n_q   <= t_n_d;
      p_n_q   <= p_n_d;
    end
  end

  assign T_n     = t_n_q;
  assign T10_n   = t_n_q[9];
  assign P01_n   = p_n_q[0];
  assign P02_n   = p_n_q[1];
  assign P03_n   = p_n_q[2];
  assign P04_n   = p_n_q[3];
  assign RT_n    = p_n_q[0];
  assign CT_n    = p_n_q[1];
  assign WT_n    = p_n_q[2];
  assign TT_n    = p_n_q[3];
  assign STOPPED = (state_q == S_STOPPED);
  assign MCT_CNT = mct_q;

endmodule

// File: tb/tb_timing_pulse_generator.sv
// Directed bench for timing_pulse_generator: sequencing, stop/step, GOJAM,
// reset priority, and counter wrap with six phases per time pulse.
module tb_timing_pulse_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main instance (PH_PER_T=4, MCT_W=16)
  logic        rst = 1'b1, gojam = 1'b0, mstp = 1'b0, mstrt = 1'b0;
  logic [11:0] t_n;
  logic        t10_n, p01_n, p02_n, p03_n, p04_n, rt_n, ct_n, wt_n, tt_n, stopped;
  logic [15:0] mct;

  // Wrap instance (PH_PER_T=6, MCT_W=4)
  logic        b_rst = 1'b1;
  logic [11:0] b_t_n;
  logic        b_t10_n, b_p01_n, b_p02_n, b_p03_n, b_p04_n, b_rt_n, b_ct_n, b_wt_n, b_tt_n, b_stopped;
  logic [3:0]  b_mct;

  timing_pulse_generator u_dut (
    .SIM_CLK(clk), .SIM_RST(rst), .p4VSW(1'b1), .GND(1'b0),
    .GOJAM(gojam), .MSTP(mstp), .MSTRT(mstrt),
    .T_n(t_n), .T10_n(t10_n), .P01_n(p01_n), .P02_n(p02_n), .P03_n(p03_n), .P04_n(p04_n),
    .RT_n(rt_n), .CT_n(ct_n), .WT_n(wt_n), .TT_n(tt_n), .STOPPED(stopped), .MCT_CNT(mct)
  );

  timing_pulse_generator #(.T_PER_MCT(12), .PH_PER_T(6), .MCT_W(4)) u_dut_b (
    .SIM_CLK(clk), .SIM_RST(b_rst), .p4VSW(1'b1), .GND(1'b0),
    .GOJAM(1'b0), .MSTP(1'b0), .MSTRT(1'b0),
    .T_n(b_t_n), .T10_n(b_t10_n), .P01_n(b_p01_n), .P02_n(b_p02_n), .P03_n(b_p03_n), .P04_n(b_p04_n),
    .RT_n(b_rt_n), .CT_n(b_ct_n), .WT_n(b_wt_n), .TT_n(b_tt_n), .STOPPED(b_stopped), .MCT_CNT(b_mct)
  );

  // {T_n, T10_n, P01..P04, RT CT WT TT, STOPPED}
  logic [21:0] obs, b_obs;
  assign obs   = {t_n, t10_n, p01_n, p02_n, p03_n, p04_n, rt_n, ct_n, wt_n, tt_n, stopped};
  assign b_obs = {b_t_n, b_t10_n, b_p01_n, b_p02_n, b_p03_n, b_p04_n,
                  b_rt_n, b_ct_n, b_wt_n, b_tt_n, b_stopped};

  function automatic logic [21:0] exp_vec(input int tp, input int ph, input bit halted);
    logic [11:0] t;
    logic [3:0]  p;
    if (halted) return {12'hFFF, 1'b1, 4'hF, 4'hF, 1'b1};
    t = 12'hFFF;
    t[tp] = 1'b0;
    p = 4'hF;
    if (ph < 4) p[3-ph] = 1'b0;
    return {t, (tp != 9), p, p, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; gojam = 1'b0; mstp = 1'b0; mstrt = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== exp_vec(0, 0, 0)) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs, exp_vec(0, 0, 0));
    end
    checks++;
    if (mct !== 16'd0) begin
      errors++; $display("FAIL reset_mct: got %0d expected 0", mct);
    end
  endtask

  task automatic test_run();
    do_reset();
    for (int n = 0; n < 48; n++) begin
      checks++;
      if (obs !== exp_vec(n / 4, n % 4, 0)) begin
        errors++; $display("FAIL run_seq cycle %0d: got %h expected %h", n, obs, exp_vec(n / 4, n % 4, 0));
      end
      tick();
    end
    checks++;
    if (obs !== exp_vec(0, 0, 0) || mct !== 16'd1) begin
      errors++; $display("FAIL run_wrap: got %h mct=%0d expected %h mct=1", obs, mct, exp_vec(0, 0, 0));
    end
  endtask

  task automatic test_stop_step();
    do_reset();
    for (int n = 0; n < 48; n++) begin
      if (n == 10) mstp = 1'b1;
      mstrt = (n == 20 || n == 21);   // an edge during RUN must be forgotten
      checks++;
      if (obs !== exp_vec(n / 4, n % 4, 0)) begin
        errors++; $display("FAIL stop_run cycle %0d: got %h expected %h", n, obs, exp_vec(n / 4, n % 4, 0));
      end
      tick();
    end
    for (int n = 0; n < 100; n++) begin
      checks++;
      if (obs !== exp_vec(0, 0, 1) || mct !== 16'd1) begin
        errors++; $display("FAIL stop_hold cycle %0d: got %h mct=%0d expected %h mct=1", n, obs, mct, exp_vec(0, 0, 1));
      end
      tick();
    end
    // Five-cycle MSTRT pulse: one MCT step
    mstrt = 1'b1;
    tick();
    for (int n = 0; n < 48; n++) begin
      if (n == 4) mstrt = 1'b0;
      checks++;
      if (obs !== exp_vec(n / 4, n % 4, 0)) begin
        errors++; $display("FAIL step_run cycle %0d: got %h expected %h", n, obs, exp_vec(n / 4, n % 4, 0));
      end
      tick();
    end
    checks++;
    if (obs !== exp_vec(0, 0, 1) || mct !== 16'd2) begin
      errors++; $display("FAIL step_restop: got %h mct=%0d expected %h mct=2", obs, mct, exp_vec(0, 0, 1));
    end
    // MSTRT held high: one step, then level alone does nothing
    mstrt = 1'b1;
    tick();
    for (int n = 0; n < 48; n++) tick();
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (obs !== exp_vec(0, 0, 1) || mct !== 16'd3) begin
        errors++; $display("FAIL step_level cycle %0d: got %h mct=%0d expected %h mct=3", n, obs, mct, exp_vec(0, 0, 1));
      end
      tick();
    end
    mstrt = 1'b0;
    mstp = 1'b0;
    tick();
    checks++;
    if (obs !== exp_vec(0, 0, 1)) begin
      errors++; $display("FAIL stop_clear_mstp: got %h expected %h", obs, exp_vec(0, 0, 1));
    end
  endtask

  task automatic test_gojam();
    do_reset();
    for (int n = 0; n < 48 + 26; n++) tick();   // now at tp=6 ph=2, mct=1
    gojam = 1'b1;
    tick();
    gojam = 1'b0;
    checks++;
    if (obs !== exp_vec(0, 0, 0) || mct !== 16'd1) begin
      errors++; $display("FAIL gojam_pulse: got %h mct=%0d expected %h mct=1", obs, mct, exp_vec(0, 0, 0));
    end
    tick();
    checks++;
    if (obs !== exp_vec(0, 1, 0)) begin
      errors++; $display("FAIL gojam_after: got %h expected %h", obs, exp_vec(0, 1, 0));
    end
    gojam = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (obs !== exp_vec(0, 0, 0)) begin
        errors++; $display("FAIL gojam_held cycle %0d: got %h expected %h", n, obs, exp_vec(0, 0, 0));
      end
    end
    gojam = 1'b0;
    mstp = 1'b1;
    for (int n = 0; n < 48; n++) tick();
    checks++;
    if (obs !== exp_vec(0, 0, 1) || mct !== 16'd2) begin
      errors++; $display("FAIL gojam_prestop: got %h mct=%0d expected %h mct=2", obs, mct, exp_vec(0, 0, 1));
    end
    gojam = 1'b1;
    tick();
    gojam = 1'b0;
    checks++;
    if (obs !== exp_vec(0, 0, 0) || mct !== 16'd2) begin
      errors++; $display("FAIL gojam_stopped: got %h mct=%0d expected %h mct=2", obs, mct, exp_vec(0, 0, 0));
    end
    mstp = 1'b0;
    tick();
    checks++;
    if (obs !== exp_vec(0, 1, 0)) begin
      errors++; $display("FAIL gojam_resume: got %h expected %h", obs, exp_vec(0, 1, 0));
    end
  endtask

  task automatic test_sim_rst();
    do_reset();
    for (int n = 0; n < 48 + 39; n++) tick();   // tp=9 ph=3, mct=1
    checks++;
    if (obs !== exp_vec(9, 3, 0) || mct !== 16'd1) begin
      errors++; $display("FAIL rst_pre: got %h mct=%0d expected %h mct=1", obs, mct, exp_vec(9, 3, 0));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs !== exp_vec(0, 0, 0) || mct !== 16'd0) begin
      errors++; $display("FAIL rst_mid: got %h mct=%0d expected %h mct=0", obs, mct, exp_vec(0, 0, 0));
    end
    for (int n = 0; n < 48 + 10; n++) tick();
    rst = 1'b1; gojam = 1'b1;
    tick();
    rst = 1'b0; gojam = 1'b0;
    checks++;
    if (obs !== exp_vec(0, 0, 0) || mct !== 16'd0) begin
      errors++; $display("FAIL rst_gojam: got %h mct=%0d expected %h mct=0", obs, mct, exp_vec(0, 0, 0));
    end
    mstp = 1'b1;
    for (int n = 0; n < 48; n++) tick();
    mstp = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs !== exp_vec(0, 0, 0) || mct !== 16'd0) begin
      errors++; $display("FAIL rst_stopped: got %h mct=%0d expected %h mct=0", obs, mct, exp_vec(0, 0, 0));
    end
  endtask

  task automatic test_wrap_six_phase();
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    for (int n = 0; n <= 72 * 16; n++) begin
      checks++;
      if (b_obs !== exp_vec((n / 6) % 12, n % 6, 0)) begin
        errors++; $display("FAIL wrap_seq cycle %0d: got %h expected %h", n, b_obs, exp_vec((n / 6) % 12, n % 6, 0));
      end
      if (n % 72 == 0) begin
        checks++;
        if (b_mct !== 4'((n / 72) % 16)) begin
          errors++; $display("FAIL wrap_mct cycle %0d: got %0d expected %0d", n, b_mct, (n / 72) % 16);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stop_step();
    test_gojam();
    test_sim_rst();
    test_wrap_six_phase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
